// File: rtl/ysyx_22040759_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22040759_pkg
// Shared constants and types for the ysyx_22040759 core front end.
//   ADDR_W / INST_W : address (64) and instruction (32) widths
//   RESET_PC        : PC loaded on reset
//   NOP             : canonical addi x0,x0,0, used by decode for flushed slots
//   fetch_entry_t   : one fetched instruction as held in the fetch buffer
// ---------------------------------------------------------------------------
package ysyx_22040759_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned INST_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC   = 64'h8000_0000;
  localparam logic [INST_W-1:0] NOP        = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] INST_BYTES = 64'd4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              misalign;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Instructions are 4-byte aligned; anything else is flagged for a trap
  // further down the pipe.
  function automatic logic is_misaligned(input logic [ADDR_W-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_22040759_fetch_fifo.sv
// ---------------------------------------------------------------------------
// ysyx_22040759_fetch_fifo
// Small synchronous FIFO holding fetched entries between IF and ID.
//   clk, rst : clock, synchronous active-high reset
//   push     : write din this cycle (ignored when full and not popping)
//   pop      : drop the head entry this cycle (ignored when empty)
//   flush    : empty the FIFO; overrides push and pop
//   din      : entry to write
//   dout     : head entry (contents meaningless when count is 0)
//   count    : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ysyx_22040759_fetch_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign do_pop  = pop & (count_q != '0);
  assign do_push = push & ((count_q != DEPTH_C) | do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count_q alone decides
  // whether an entry is visible, so resetting data would only cost flops.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ysyx_22040759_if_stage.sv
// ---------------------------------------------------------------------------
// ysyx_22040759_if_stage
// Instruction fetch: owns the PC, addresses the instruction RAM and buffers
// {pc, inst, misalign} for decode behind a valid/ready handshake.
//   clk, rst           : clock, synchronous active-high reset
//   inst_raddr         : RAM byte address, straight from the PC register
//   inst               : RAM data for inst_raddr, same cycle
//   redirect_valid/_pc : branch/jump/trap target; flushes the buffer
//   id_valid/id_ready  : handshake with decode
//   id_pc/id_inst/id_misalign : head entry, forced to 0 when id_valid is 0
// ---------------------------------------------------------------------------
module ysyx_22040759_if_stage #(
  parameter logic [63:0]  RESET_PC = ysyx_22040759_pkg::RESET_PC,
  parameter int unsigned  DEPTH    = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic [ysyx_22040759_pkg::ADDR_W-1:0] inst_raddr,
  input  logic [ysyx_22040759_pkg::INST_W-1:0] inst,
  input  logic                               redirect_valid,
  input  logic [ysyx_22040759_pkg::ADDR_W-1:0] redirect_pc,
  output logic                               id_valid,
  input  logic                               id_ready,
  output logic [ysyx_22040759_pkg::ADDR_W-1:0] id_pc,
  output logic [ysyx_22040759_pkg::INST_W-1:0] id_inst,
  output logic                               id_misalign
);

  import ysyx_22040759_pkg::*;

  localparam int unsigned      CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  fifo_count;
  fetch_entry_t      push_entry, head_entry;
  logic              pop, space, push;

  assign id_valid = (fifo_count != '0);
  assign pop      = id_valid & id_ready;
  // Counting the departing head as free space keeps a full buffer streaming
  // one instruction per cycle once decode is ready again.
  assign space    = (fifo_count < DEPTH_C) | pop;
  assign push     = space & ~redirect_valid;

  assign push_entry = '{pc: pc_q, inst: inst, misalign: is_misaligned(pc_q)};

  // Next-PC mux: redirect beats everything; otherwise advance only when the
  // fetched word was actually captured, so inst_raddr holds while stalled.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_pc;
    else if (space)     pc_d = pc_q + INST_BYTES;
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  // A handshake in a redirect cycle is void; flush already wins inside the
  // FIFO, so pop can be passed straight through.
  ysyx_22040759_fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .dout  (head_entry),
    .count (fifo_count)
  );

  assign inst_raddr  = pc_q;
  assign id_pc       = head_entry.pc   & {ADDR_W{id_valid}};
  assign id_inst     = head_entry.inst & {INST_W{id_valid}};
  assign id_misalign = head_entry.misalign & id_valid;

endmodule

// File: doc/ysyx_22040759_if_stage.md
# ysyx_22040759_if_stage

Instruction-fetch stage that owns the program counter, drives the address into the instruction RAM (combinational 32-bit read from a 64-bit byte address), and captures each returned instruction with its PC into a 2-entry buffer. It presents those entries to decode over a valid/ready handshake. It sits between the branch/redirect logic (EX/WB) and the decoder. It absorbs decode back-pressure and flushes on redirect.

## Interface
- `RESET_PC`, default 64'h8000_0000: PC value loaded on reset.
- `DEPTH`, default 2: buffer entries; only 2 is required to be supported.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `inst_raddr`  out  64: byte address to the instruction RAM; equals the current PC register.
- `inst`  in  32: instruction returned combinationally for `inst_raddr` in the same cycle.
- `redirect_valid`  in  1: taken branch, jump or trap; replace the PC and flush.
- `redirect_pc`  in  64: new PC when `redirect_valid` is 1.
- `id_valid`  out  1: buffer head is valid.
- `id_ready`  in  1: decode accepts the head this cycle.
- `id_pc`  out  64: PC of the head entry; 0 when `id_valid` is 0.
- `id_inst`  out  32: instruction of the head entry; 0 when `id_valid` is 0.
- `id_misalign`  out  1: head PC has `pc[1:0]` not equal to 0; 0 when `id_valid` is 0.

## Operation
- State:
  - 64-bit `pc` register.
  - Buffer of up to DEPTH entries `{pc, inst, misalign}`.
  - Occupancy count of 0..DEPTH.
  - Read and write pointers of 1 bit each, which wrap.
- Definitions:
  - `pop` = `id_valid & id_ready`.
  - `space` = (count < DEPTH) | `pop`.
- Normal cycle (no redirect):
  - If `space`: push `{pc, inst, pc[1:0]!=0}` and set `pc <= pc + 4` (64-bit, wraps modulo 2^64).
  - Otherwise: `pc` holds and there is no push. `inst_raddr` stays stable, so the RAM value does not change.
- Push and pop in the same cycle: count is unchanged. This is allowed both when full and when holding one entry.
- Pop when empty: impossible, because `id_valid` is 0.
- Redirect (`redirect_valid` = 1):
  - Takes priority over everything else.
  - Count is set to 0 and both pointers to 0.
  - There is no push that cycle.
  - `pc <= redirect_pc`.
  - A simultaneous `pop` is discarded and counts for nothing; decode must treat a redirect-cycle handshake as void.
- Misaligned `redirect_pc`: fetch proceeds. Entries carry `id_misalign` = 1, and the PC keeps incrementing by 4 from the misaligned value. Trap handling belongs downstream.
- Output masking: `id_pc`, `id_inst` and `id_misalign` are ANDed with `id_valid`.
- Reset during operation: applies the same state as power-on reset on the next edge. All in-flight entries are lost.
- Reset state:
  - `pc` = `RESET_PC`, so `inst_raddr` = 64'h8000_0000.
  - count = 0 and pointers = 0.
  - `id_valid` = 0, `id_pc` = 0, `id_inst` = 0, `id_misalign` = 0.

## Timing
- Fetch-to-decode latency is 1 cycle. The instruction at `inst_raddr` in cycle N appears on `id_*` with `id_valid` = 1 in cycle N+1.
- Steady state with `id_ready` held at 1 gives one instruction per cycle with no bubbles.
- `id_ready` going low:
  - The buffer fills by the end of the second cycle.
  - `pc` freezes from then on.
  - No entry is dropped or duplicated.
- `id_ready` returning high: issue resumes in the same cycle. The next push also lands that cycle, because `space` includes `pop`.
- Redirect asserted in cycle N:
  - `id_valid` = 0 in cycle N+1.
  - `inst_raddr` = `redirect_pc` in cycle N+1.
  - The first redirected entry is valid in cycle N+2 (2-cycle redirect penalty).
- Redirects in back-to-back cycles: the last one wins.
- `id_*` outputs come from registers, masked by `id_valid`; there is no combinational path from `inst` to `id_*`.
- `inst_raddr` comes directly from the `pc` register.

## Structure
- Shared define/package (the team's define file):
  - `RESET_PC` constant.
  - Instruction width (32) and address width (64).
  - `NOP` constant 32'h0000_0013, used by decode for flushed slots.
- Sub-module `ysyx_22040759_fetch_fifo`:
  - Parameterised-width, DEPTH-entry synchronous FIFO.
  - Ports: `push`, `pop`, `flush`, `din`, `dout`, `count`.
  - `flush` overrides `push` and `pop`.
- Top level holds the `pc` register, the next-PC mux (redirect / +4 / hold), and the output masking.

## Test plan
- Reset, then `id_ready` = 1 with RAM words 0x00000013, 0x00100093 at 0x80000000 and 0x80000004:
  - `inst_raddr` = 0x80000000 in the first cycle.
  - Next cycle: `id_valid` = 1, `id_pc` = 0x80000000, `id_inst` = 0x00000013.
  - Following cycle: `id_pc` = 0x80000004, `id_inst` = 0x00100093.
- `id_ready` = 0 for 5 cycles after reset:
  - count saturates at 2 and `inst_raddr` freezes at 0x80000008.
  - On release, `id_pc` runs 0x80000000, 0x80000004, 0x80000008 with no gaps and no repeats.
- Buffer full with `id_ready` = 1 for one cycle:
  - Push and pop occur together and count stays 2.
  - `inst_raddr` advances by exactly 4.
- Redirect to 0x80000100 while 2 entries are held and `id_ready` = 1:
  - Next cycle: `id_valid` = 0 and `inst_raddr` = 0x80000100.
  - Cycle after: `id_pc` = 0x80000100.
- Redirect to 0x80000102: the entry shows `id_misalign` = 1, and the next entry has `id_pc` = 0x80000106.
- `rst` asserted mid-stream with the buffer full:
  - Next cycle: `id_valid` = 0, all `id_*` are 0, and `inst_raddr` = 0x80000000.
